// File: rtl/tlc_np_if.sv
// Master/slave bundle between the N-phase traffic-light master and the per-approach slaves.
interface tlc_np_if #(
    parameter int unsigned NPH = 4,
    parameter int unsigned PW  = 2
);
    logic [NPH-1:0] req;
    logic           ok;
    logic [PW-1:0]  dir;
    logic           green;
    logic           yellow;
    logic           all_red;
    logic           new_phase;

    modport master (
        input  req, ok,
        output dir, green, yellow, all_red, new_phase
    );

    modport slave (
        output req, ok,
        input  dir, green, yellow, all_red, new_phase
    );
endinterface

// File: rtl/tlc_master_np.sv
// N-phase traffic-light master: home phase 0 plus round-robin side phases,
// min/max green, yellow and all-red clearance, each green exit gated by slave ok.
module tlc_master_np #(
    parameter int unsigned NPH         = 4,
    parameter int unsigned PW          = 2,
    parameter int unsigned TWIDTH      = 4,
    parameter int unsigned T_MIN_GREEN = 3,
    parameter int unsigned T_MAX_GREEN = 12,
    parameter int unsigned T_YELLOW    = 3,
    parameter int unsigned T_ALLRED    = 1
) (
    input  logic      clk,
    input  logic      rst,
    tlc_np_if.master  bus
);

    localparam int unsigned IW       = (NPH > 2) ? $clog2(NPH) : 1;
    localparam int unsigned CNT_MAX  = (1 << TWIDTH) - 1;
    localparam int unsigned NSIDE    = NPH - 1;

    localparam logic [TWIDTH-1:0] CNT_SAT  = TWIDTH'(CNT_MAX);
    localparam logic [TWIDTH-1:0] MIN_LAST = TWIDTH'(T_MIN_GREEN - 1);
    localparam logic [TWIDTH-1:0] MAX_LAST = TWIDTH'(T_MAX_GREEN - 1);
    localparam logic [TWIDTH-1:0] Y_LAST   = TWIDTH'(T_YELLOW - 1);
    localparam logic [TWIDTH-1:0] AR_LAST  = TWIDTH'(T_ALLRED - 1);

    // Reject parameter sets the timing and phase arithmetic cannot honour.
    if (NPH < 2 || (1 << PW) < NPH || T_MIN_GREEN < 1 || T_MIN_GREEN > T_MAX_GREEN ||
        T_MAX_GREEN > CNT_MAX || T_YELLOW < 1 || T_YELLOW > CNT_MAX ||
        T_ALLRED < 1 || T_ALLRED > CNT_MAX) begin : g_bad_params
        $error("tlc_master_np: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_GREEN  = 2'd0,
        S_YELLOW = 2'd1,
        S_ALLRED = 2'd2
    } state_t;

    state_t              state;
    logic [TWIDTH-1:0]   cnt;
    logic [PW-1:0]       dir_q;
    logic [PW-1:0]       target;
    logic [PW-1:0]       rr_last;
    logic                green_q;
    logic                yellow_q;
    logic                all_red_q;
    logic                new_phase_q;

    logic [TWIDTH-1:0]   cnt_inc;
    logic [PW-1:0]       rr_pick;
    logic                pick_found;
    int unsigned         cand;
    logic                side_req;
    logic                cur_req;
    logic                home;
    logic                min_ok;
    logic                max_done;
    logic                green_exit;
    logic [PW-1:0]       exit_target;

    assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + TWIDTH'(1);

    // Round-robin search over side phases, starting just after the last one served.
    always_comb begin
        rr_pick    = '0;
        pick_found = 1'b0;
        cand       = 0;
        for (int unsigned k = 1; k < NPH; k++) begin
            cand = ((32'(rr_last) - 1 + k) % NSIDE) + 1;
            if (!pick_found && bus.req[IW'(cand)]) begin
                rr_pick    = PW'(cand);
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        side_req    = |bus.req[NPH-1:1];
        cur_req     = bus.req[IW'(dir_q)];
        home        = (dir_q == '0);
        min_ok      = (cnt >= MIN_LAST);
        max_done    = (cnt >= MAX_LAST);
        green_exit  = min_ok && bus.ok && (home ? side_req : (!cur_req || max_done));
        exit_target = home ? rr_pick : '0;
    end

    // Phase sequencer: GREEN -> YELLOW -> ALLRED -> GREEN(target).
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_GREEN;
            cnt         <= '0;
            dir_q       <= '0;
            target      <= '0;
            rr_last     <= PW'(NPH - 1);
            green_q     <= 1'b1;
            yellow_q    <= 1'b0;
            all_red_q   <= 1'b0;
            new_phase_q <= 1'b0;
        end else begin
            new_phase_q <= 1'b0;
            case (state)
                S_GREEN: begin
                    if (green_exit) begin
                        state    <= S_YELLOW;
                        cnt      <= '0;
                        target   <= exit_target;
                        green_q  <= 1'b0;
                        yellow_q <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_YELLOW: begin
                    if (cnt >= Y_LAST) begin
                        state     <= S_ALLRED;
                        cnt       <= '0;
                        yellow_q  <= 1'b0;
                        all_red_q <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_ALLRED: begin
                    if (cnt >= AR_LAST) begin
                        state       <= S_GREEN;
                        cnt         <= '0;
                        dir_q       <= target;
                        all_red_q   <= 1'b0;
                        green_q     <= 1'b1;
                        new_phase_q <= 1'b1;
                        if (target != '0) begin
                            rr_last <= target;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state     <= S_GREEN;
                    cnt       <= '0;
                    dir_q     <= '0;
                    green_q   <= 1'b1;
                    yellow_q  <= 1'b0;
                    all_red_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dir       = dir_q;
    assign bus.green     = green_q;
    assign bus.yellow    = yellow_q;
    assign bus.all_red   = all_red_q;
    assign bus.new_phase = new_phase_q;

endmodule

// File: tb/tb_tlc_master_np.sv
// Scoreboard bench for tlc_master_np: default 4-phase instance plus a 6-phase, 2-cycle all-red instance.
module tb_tlc_master_np;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    always #5 clk = ~clk;

    tlc_np_if #(.NPH(4), .PW(2)) ifa ();
    tlc_np_if #(.NPH(6), .PW(3)) ifb ();

    tlc_master_np dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa)
    );

    tlc_master_np #(
        .NPH(6), .PW(3), .TWIDTH(4), .T_MIN_GREEN(3), .T_MAX_GREEN(12),
        .T_YELLOW(3), .T_ALLRED(2)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb)
    );

    typedef struct {
        bit          b;
        int unsigned tst;
        int unsigned cyc;
        logic [2:0]  dir;
        logic        g;
        logic        y;
        logic        ar;
        logic        np;
    } exp_t;

    exp_t        q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned tnum   = 0;
    int unsigned cyc    = 0;

    // Monitor: pops one expectation per cycle and compares it mid-cycle.
    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [6:0] act;
        logic [6:0] want;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.b) act = {ifb.dir, ifb.green, ifb.yellow, ifb.all_red, ifb.new_phase};
            else     act = {1'b0, ifa.dir, ifa.green, ifa.yellow, ifa.all_red, ifa.new_phase};
            want = {e.dir, e.g, e.y, e.ar, e.np};
            checks++;
            if (act !== want) begin
                errors++;
                $display("FAIL test%0d cyc%0d {dir,g,y,ar,np}: got %b_%b%b%b%b expected %b_%b%b%b%b",
                         e.tst, e.cyc, act[6:4], act[3], act[2], act[1], act[0],
                         want[6:4], want[3], want[2], want[1], want[0]);
            end
        end
    end

    task automatic step(input bit b, input logic [5:0] r, input logic o,
                        input logic [2:0] d, input logic g, input logic y,
                        input logic ar, input logic np);
        exp_t e;
        if (b) begin
            ifb.req = r;
            ifb.ok  = o;
        end else begin
            ifa.req = r[3:0];
            ifa.ok  = o;
        end
        e.b = b; e.tst = tnum; e.cyc = cyc;
        e.dir = d; e.g = g; e.y = y; e.ar = ar; e.np = np;
        q.push_back(e);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic grn(input bit b, input logic [5:0] r, input logic o,
                       input logic [2:0] d, input int n, input logic np_first);
        for (int i = 0; i < n; i++) step(b, r, o, d, 1'b1, 1'b0, 1'b0, (i == 0) ? np_first : 1'b0);
    endtask

    task automatic yar(input bit b, input logic [5:0] r, input logic [2:0] d, input int nar);
        for (int i = 0; i < 3; i++)   step(b, r, 1'b1, d, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < nar; i++) step(b, r, 1'b1, d, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic reset_a(input int unsigned t);
        tnum  = t;
        cyc   = 0;
        rst_a = 1'b1;
        ifa.req = '0;
        ifa.ok  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        ifa.req = '0; ifa.ok = 1'b0;
        ifb.req = '0; ifb.ok = 1'b0;

        // 1: idle home phase.
        reset_a(1);
        grn(0, 6'b000000, 1'b1, 3'd0, 20, 1'b0);

        // 2: single side request, then demand drops on the side green.
        reset_a(2);
        grn(0, 6'b000100, 1'b1, 3'd0, 3, 1'b0);
        yar(0, 6'b000100, 3'd0, 1);
        grn(0, 6'b000000, 1'b1, 3'd2, 3, 1'b1);
        yar(0, 6'b000000, 3'd2, 1);
        grn(0, 6'b000000, 1'b1, 3'd0, 4, 1'b1);

        // 3: two contending side phases, each held to max green.
        reset_a(3);
        for (int k = 0; k < 2; k++) begin
            grn(0, 6'b001010, 1'b1, 3'd0, 3, (k == 0) ? 1'b0 : 1'b1);
            yar(0, 6'b001010, 3'd0, 1);
            grn(0, 6'b001010, 1'b1, 3'd1, 12, 1'b1);
            yar(0, 6'b001010, 3'd1, 1);
            grn(0, 6'b001010, 1'b1, 3'd0, 3, 1'b1);
            yar(0, 6'b001010, 3'd0, 1);
            grn(0, 6'b001010, 1'b1, 3'd3, 12, 1'b1);
            yar(0, 6'b001010, 3'd3, 1);
        end
        grn(0, 6'b000000, 1'b1, 3'd0, 1, 1'b1);

        // 4: slave not ready holds the green past its minimum.
        reset_a(4);
        grn(0, 6'b000010, 1'b0, 3'd0, 10, 1'b0);
        grn(0, 6'b000010, 1'b1, 3'd0, 1, 1'b0);
        yar(0, 6'b000010, 3'd0, 1);
        grn(0, 6'b000010, 1'b1, 3'd1, 1, 1'b1);

        // 5: reset mid-yellow toward phase 3 clears round-robin history.
        reset_a(5);
        grn(0, 6'b000010, 1'b1, 3'd0, 3, 1'b0);
        yar(0, 6'b000010, 3'd0, 1);
        grn(0, 6'b000000, 1'b1, 3'd1, 3, 1'b1);
        yar(0, 6'b000000, 3'd1, 1);
        grn(0, 6'b001000, 1'b1, 3'd0, 3, 1'b1);
        step(0, 6'b001000, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        rst_a = 1'b1;
        step(0, 6'b001000, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        rst_a = 1'b0;
        grn(0, 6'b001010, 1'b1, 3'd0, 3, 1'b0);
        yar(0, 6'b001010, 3'd0, 1);
        grn(0, 6'b001010, 1'b1, 3'd1, 1, 1'b1);

        // 6: six phases with two-cycle all-red.
        tnum  = 6;
        cyc   = 0;
        ifb.req = '0;
        ifb.ok  = 1'b1;
        rst_b   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b0;
        grn(1, 6'b100000, 1'b1, 3'd0, 3, 1'b0);
        yar(1, 6'b100000, 3'd0, 2);
        grn(1, 6'b100000, 1'b1, 3'd5, 2, 1'b1);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlc_master_np.md
Name: tlc_master_np

Overview:
N-phase traffic-light master controller. It generalises the fixed NS/EW/LT master to NPH phases, with configurable minimum/maximum green, yellow and all-red clearance intervals. It uses round-robin arbitration among the side phases. It sits above the per-approach light slaves: it drives the phase index plus green/yellow/all-red indications and uses the slaves' `ok` handshake to gate every phase change.

Parameters:
- NPH, 4: number of phases. Phase 0 is the home (main) phase; 1..NPH-1 are side phases. NPH must be at least 2.
- PW, 2: phase index width. ceil(log2(NPH)) must be at most PW.
- TWIDTH, 4: interval counter width.
- T_MIN_GREEN, 3: minimum green cycles before any exit. Must be at least 1.
- T_MAX_GREEN, 12: side-phase green timeout in cycles. Must satisfy T_MIN_GREEN <= T_MAX_GREEN <= 2^TWIDTH-1.
- T_YELLOW, 3: yellow cycles. Must be at least 1.
- T_ALLRED, 1: all-red clearance cycles. Must be at least 1.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- req, input, NPH: per-phase demand (car present). req[0] is ignored.
- ok, input, 1: slave-ready handshake. A GREEN exit happens only while ok=1.
- dir, output, PW: current phase index.
- green, output, 1: high in the GREEN state.
- yellow, output, 1: high in the YELLOW state.
- all_red, output, 1: high in the ALLRED state.
- new_phase, output, 1: one-cycle pulse on the first GREEN cycle of each new phase.

Behaviour:
- All outputs and state are registered and update on posedge clk.
- Reset (rst=1 at an edge) sets: state=GREEN, dir=0, green=1, yellow=0, all_red=0, new_phase=0, cnt=0, target=0, rr_last=NPH-1.
- Reset applies from any state, including mid-yellow or mid-all-red, and overrides every other transition in the same cycle.
- cnt counts cycles in the current state. It is cleared to 0 on every state entry and saturates at 2^TWIDTH-1.
- GREEN state:
  - min_ok = (cnt >= T_MIN_GREEN-1).
  - max_done = (cnt >= T_MAX_GREEN-1).
  - When dir=0: exit when min_ok & ok & (|req[NPH-1:1]). target = first requesting side phase found searching rr_last+1, rr_last+2, ..., wrapping from NPH-1 to 1 and skipping 0.
  - When dir=p, p!=0: exit when min_ok & ok & (!req[p] | max_done). target=0.
  - While ok=0, no exit occurs and cnt keeps counting (saturating).
  - Green length is at least T_MIN_GREEN cycles. A side-phase green with continuous demand and ok=1 lasts exactly T_MAX_GREEN cycles.
- Exit from GREEN: the next state is YELLOW; target is latched and dir is unchanged.
- YELLOW: lasts exactly T_YELLOW cycles, then goes to ALLRED. ok and req are ignored.
- ALLRED: lasts exactly T_ALLRED cycles. On leaving: state=GREEN, dir=target, new_phase=1 for one cycle, and rr_last=target if target!=0.
- Home phase with no side demand stays in GREEN indefinitely, with new_phase=0.
- Side-phase demand that drops while in YELLOW or ALLRED does not abort the sequence; the phase is still served.
- The phase encoding is one-hot among green/yellow/all_red; exactly one of them is high at all times.

Test Plan:
1. rst for 2 cycles, then req=0, ok=1 for 20 cycles -> dir=0, green=1 throughout, new_phase never pulses.
2. Defaults, with req[2]=1 and ok=1 from the first cycle after reset (cycle 0):
   - Cycles 0-2: GREEN dir=0.
   - Cycles 3-5: yellow.
   - Cycle 6: all_red.
   - Cycle 7: green, dir=2, new_phase=1.
   - Then drop req[2] -> 3-cycle green, 3-cycle yellow, 1-cycle all_red, then dir=0.
3. req[1]=req[3]=1 held, ok=1 -> side phases served in order 1, 3, 1, 3, each followed by a home-phase green. Each side green is exactly 12 cycles (max timeout).
4. req[1]=1 with ok=0 for 10 cycles, then ok=1 -> no yellow while ok=0; yellow begins on the edge after ok rises (cnt is already at or above the minimum).
5. rst asserted on the 2nd yellow cycle of a transition to phase 3 -> the next cycle shows dir=0, green=1, yellow=0. The next side request restarts round-robin from phase 1.
6. Parameter sweep NPH=6, PW=3, T_ALLRED=2, req[5]=1 -> dir reaches 5 after the min green + 3 yellow + 2 all_red cycles; all_red is high for exactly 2 cycles.
